tape_mem: RTL and testbench

- Memory responder for the data tape; it is the far end of the fixed-latency read channel driven by the register-select stage (`mem_en_out`/`mem_addr_out`, consumed back as `mem_data_in`). It also accepts the retire stage's write-backs of evicted or modified cells.
- Read latency is exactly 2 cycles with no backpressure, so the select stage's `mem_en`→`mem_en1`→`mem_en2` chain lines up with returned data.
- After reset the block clears the whole tape to zero, as the language requires, before it services any traffic.

---
 rtl/tape_mem_if.sv | 22 ++
 rtl/tape_mem.sv | 98 +++++++++
 tb/tb_tape_mem.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/tape_mem_if.sv
// Bus bundle between the tape users and the tape memory.
// master: read/write requesters; slave: tape_mem.
interface tape_mem_if;
    logic        mem_en;
    logic [15:0] mem_addr;
    logic [15:0] mem_data_out;
    logic        mem_valid;
    logic        wr_en;
    logic [15:0] wr_addr;
    logic [15:0] wr_data;
    logic        ready;

    modport master (
        output mem_en, mem_addr, wr_en, wr_addr, wr_data,
        input  mem_data_out, mem_valid, ready
    );

    modport slave (
        input  mem_en, mem_addr, wr_en, wr_addr, wr_data,
        output mem_data_out, mem_valid, ready
    );
endinterface

// File: rtl/tape_mem.sv
// Data tape memory: 2-cycle read pipe, write port, zero-clear on reset.
// Ports: clk, rst_n (sync, active low), bus (tape_mem_if.slave).
module tape_mem #(
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input logic       clk,
    input logic       rst_n,
    tape_mem_if.slave bus
);
    typedef enum logic {S_CLEAR, S_RUN} state_e;

    state_e          state_q, state_d;
    logic [AW-1:0]   cnt_q, cnt_d;
    logic            s1_vld_q, s1_vld_d;
    logic [AW-1:0]   s1_idx_q, s1_idx_d;
    logic            out_vld_q, out_vld_d;
    logic [15:0]     dout_q, dout_d;
    logic [15:0]     mem_q [DEPTH];

    logic [AW-1:0]   rd_idx;
    logic [AW-1:0]   wr_idx;
    logic            we;
    logic [AW-1:0]   we_idx;
    logic [15:0]     we_data;

    assign rd_idx = bus.mem_addr[AW-1:0];
    assign wr_idx = bus.wr_addr[AW-1:0];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        we        = 1'b0;
        we_idx    = wr_idx;
        we_data   = bus.wr_data;
        s1_vld_d  = 1'b0;
        s1_idx_d  = s1_idx_q;
        out_vld_d = 1'b0;
        dout_d    = dout_q;
        unique case (state_q)
            S_CLEAR: begin
                // one cell per cycle; user traffic is ignored
                we      = 1'b1;
                we_idx  = cnt_q;
                we_data = '0;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == AW'(DEPTH - 1)) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                we       = bus.wr_en;
                s1_vld_d = bus.mem_en;
                if (bus.mem_en) begin
                    s1_idx_d = rd_idx;
                end
                if (s1_vld_q) begin
                    out_vld_d = 1'b1;
                    // write landing on this edge wins over the array
                    if (bus.wr_en && (wr_idx == s1_idx_q)) begin
                        dout_d = bus.wr_data;
                    end else begin
                        dout_d = mem_q[s1_idx_q];
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_CLEAR;
            cnt_q     <= '0;
            s1_vld_q  <= 1'b0;
            s1_idx_q  <= '0;
            out_vld_q <= 1'b0;
            dout_q    <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            s1_vld_q  <= s1_vld_d;
            s1_idx_q  <= s1_idx_d;
            out_vld_q <= out_vld_d;
            dout_q    <= dout_d;
        end
    end

    // array has no reset; the CLEAR sweep zeroes it
    always_ff @(posedge clk) begin
        if (rst_n && we) begin
            mem_q[we_idx] <= we_data;
        end
    end

    assign bus.mem_data_out = dout_q;
    assign bus.mem_valid    = out_vld_q;
    assign bus.ready        = (state_q == S_RUN);
endmodule

// File: tb/tb_tape_mem.sv
// Directed bench for tape_mem with a response scoreboard.
// Inputs driven and outputs sampled on the falling edge.
module tb_tape_mem;
    localparam int DEPTH = 64;

    typedef struct {
        logic [15:0] data;
        int          cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    tape_mem_if bus ();

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic [15:0] last_exp = '0;

    tape_mem #(.DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %h, required %h", tag, got, exp);
        end
    endtask

    task automatic step();
        exp_t e;
        @(negedge clk);
        cyc++;
        if (bus.mem_valid === 1'b1) begin
            checks++;
            assert (sb.size() != 0) else begin
                errors++;
                $error("FAIL unexp_valid: got valid data %h, required none",
                       bus.mem_data_out);
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                checks++;
                assert (bus.mem_data_out === e.data) else begin
                    errors++;
                    $error("FAIL rd_data: got %h, required %h",
                           bus.mem_data_out, e.data);
                end
                checks++;
                assert (cyc === e.cyc) else begin
                    errors++;
                    $error("FAIL rd_latency: got cycle %0d, required %0d",
                           cyc, e.cyc);
                end
            end
        end
        bus.mem_en  = 1'b0;
        bus.wr_en   = 1'b0;
        bus.wr_data = '0;
    endtask

    task automatic rd(input logic [15:0] a, input logic [15:0] exp);
        exp_t e;
        e.data = exp;
        e.cyc  = cyc + 2;
        sb.push_back(e);
        last_exp     = exp;
        bus.mem_en   = 1'b1;
        bus.mem_addr = a;
    endtask

    task automatic wr(input logic [15:0] a, input logic [15:0] d);
        bus.wr_en   = 1'b1;
        bus.wr_addr = a;
        bus.wr_data = d;
    endtask

    task automatic drain();
        repeat (4) step();
        check("sb_empty", sb.size(), 0);
    endtask

    initial begin
        int n;
        rst_n        = 1'b0;
        bus.mem_en   = 1'b0;
        bus.mem_addr = '0;
        bus.wr_en    = 1'b0;
        bus.wr_addr  = '0;
        bus.wr_data  = '0;

        step();
        step();
        check("rst_ready", bus.ready, 0);
        check("rst_valid", bus.mem_valid, 0);
        check("rst_data", bus.mem_data_out, 0);

        rst_n = 1'b1;
        n = 0;
        while (!bus.ready && n < DEPTH + 20) begin
            n++;
            step();
        end
        check("clear_len", n, DEPTH);

        rd(16'd0, 16'h0000); step();
        rd(16'd1, 16'h0000); step();
        rd(16'(DEPTH - 1), 16'h0000); step();
        rd(16'hFFFF, 16'h0000); step();
        drain();

        wr(16'd3, 16'h0005); step();
        rd(16'd3, 16'h0005); step();
        drain();

        rd(16'd7, 16'h00AA); step();
        wr(16'd7, 16'h00AA); step();
        drain();

        rd(16'd8, 16'h0000); step();
        step();
        wr(16'd8, 16'h00BB); step();
        drain();
        rd(16'd8, 16'h00BB); step();
        drain();

        rd(16'd9, 16'h0099);
        wr(16'd9, 16'h0099); step();
        drain();

        wr(16'd1, 16'd11); step();
        wr(16'd2, 16'd22); step();
        wr(16'd3, 16'd33); step();
        rd(16'd1, 16'd11); step();
        rd(16'd2, 16'd22); step();
        rd(16'd3, 16'd33); step();
        drain();

        wr(16'(DEPTH + 4), 16'h1234); step();
        rd(16'd4, 16'h1234); step();
        drain();
        check("hold_data", bus.mem_data_out, last_exp);
        check("hold_valid", bus.mem_valid, 0);

        bus.mem_en   = 1'b1;
        bus.mem_addr = 16'd3;
        step();
        rst_n = 1'b0;
        step();
        step();
        check("rst2_ready", bus.ready, 0);
        rst_n = 1'b1;
        n = 0;
        repeat (4) begin
            bus.mem_en   = 1'b1;
            bus.mem_addr = 16'd0;
            wr(16'd0, 16'hBEEF);
            n++;
            step();
        end
        while (!bus.ready && n < DEPTH + 20) begin
            n++;
            step();
        end
        check("clear2_len", n, DEPTH);
        check("clear2_sb", sb.size(), 0);

        rd(16'd3, 16'h0000); step();
        rd(16'd0, 16'h0000); step();
        drain();

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule
